instruction_memory_bank: RTL and testbench

Parametrised, clocked instruction memory for the RISC-V core. It replaces the fixed 32-byte, reset-preloaded store with a `DEPTH_BYTES` byte array that is loaded at run time through a byte-stream loader port. Fetches use a valid/ready request and a registered, back-pressurable response carrying fault codes. It sits between the fetch stage (PC source) and decode.

---
 rtl/instruction_memory_bank.sv | 105 ++++++++++
 tb/tb_instruction_memory_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_bank.sv
// instruction_memory_bank: run-time loadable byte-array instruction store with a registered, back-pressurable fetch port
// Ports:
//   clk, reset                               clock and synchronous active-high reset
//   load_en, load_valid, load_byte           byte-stream loader (ascending addresses)
//   load_done, load_count, load_err          loader status: exit pulse, bytes written, overflow flag
//   fetch_valid, fetch_pc, fetch_ready       fetch request handshake
//   instr_valid, instruction, instr_fault,
//   instr_ready                              registered response handshake with fault code
module instruction_memory_bank #(
  parameter int          DEPTH_BYTES = 1024,
  parameter int          PTR_W       = $clog2(DEPTH_BYTES) + 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic             load_valid,
  input  logic [7:0]       load_byte,
  output logic             load_done,
  output logic [PTR_W-1:0] load_count,
  output logic             load_err,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_ready,
  output logic             instr_valid,
  output logic [31:0]      instruction,
  output logic [1:0]       instr_fault,
  input  logic             instr_ready
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic {RUN, LOAD} state_t;
  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, count_q, count_d;
  logic             err_q, err_d, done_q, done_d;
  logic             iv_q, iv_d;
  logic [31:0]      instr_q, instr_d, rdata;
  logic [1:0]       fault_q, fault_d, fault;
  logic [7:0]       mem_q [DEPTH_BYTES];
  logic             accept, room, wr_en;
  assign fetch_ready = !reset && state_q == RUN && !load_en && (!iv_q || instr_ready);
  assign accept      = fetch_valid && fetch_ready;
  assign room        = ptr_q < PTR_W'(DEPTH_BYTES);
  assign wr_en       = state_q == LOAD && load_en && load_valid && room;
  // Word read uses the aligned base; faulted fetches never use rdata, so the
  // low pc bits are dropped rather than added in.
  assign rdata = {mem_q[{fetch_pc[AW-1:2], 2'd3}], mem_q[{fetch_pc[AW-1:2], 2'd2}],
                  mem_q[{fetch_pc[AW-1:2], 2'd1}], mem_q[{fetch_pc[AW-1:2], 2'd0}]};
  // Misaligned wins over out of range.
  assign fault = (fetch_pc[1:0] != 2'b00) ? 2'b01 :
                 (fetch_pc > 32'(DEPTH_BYTES - 4)) ? 2'b10 : 2'b00;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;
    iv_d    = accept ? 1'b1 : (instr_ready ? 1'b0 : iv_q);
    instr_d = accept ? ((fault != 2'b00) ? NOP_WORD : rdata) : instr_q;
    fault_d = accept ? fault : fault_q;
    if (state_q == RUN && load_en && !iv_q) begin
      state_d = LOAD;
      ptr_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == LOAD && !load_en) begin
      state_d = RUN;
      done_d  = 1'b1;
      count_d = ptr_q;
    end else if (state_q == LOAD && load_valid) begin
      ptr_d = room ? ptr_q + 1'b1 : ptr_q;
      err_d = err_q || !room;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      iv_q    <= 1'b0;
      instr_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
      iv_q    <= iv_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end
  // Storage is deliberately not reset: a reset mid-load keeps written bytes.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[ptr_q[AW-1:0]] <= load_byte;
  end
  assign load_done   = done_q;
  assign load_count  = count_q;
  assign load_err    = err_q;
  assign instr_valid = iv_q;
  assign instruction = instr_q;
  assign instr_fault = fault_q;
endmodule

// File: tb/tb_instruction_memory_bank.sv
// tb_instruction_memory_bank: directed, table-driven checks of loader and fetch port
module tb_instruction_memory_bank;
  localparam int D  = 64;
  localparam int PW = $clog2(D) + 1;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0, load_valid = 1'b0;
  logic [7:0]    load_byte = '0;
  logic          load_done, load_err;
  logic [PW-1:0] load_count;
  logic          fetch_valid = 1'b0;
  logic [31:0]   fetch_pc = '0;
  logic          fetch_ready, instr_valid;
  logic [31:0]   instruction;
  logic [1:0]    instr_fault;
  logic          instr_ready = 1'b1;
  int            checks = 0, errors = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } vec_t;
  vec_t vecs [9];
  logic [7:0] prog [8];

  instruction_memory_bank #(.DEPTH_BYTES(D)) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
    .load_done(load_done), .load_count(load_count), .load_err(load_err),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instruction(instruction), .instr_fault(instr_fault),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fetch_one(input string nm, input logic [31:0] pc,
                           input logic [31:0] exp_i, input logic [1:0] exp_f);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    #1;
    chk({nm, "_ready"}, 32'(fetch_ready), 32'd1);
    step();
    fetch_valid = 1'b0;
    chk({nm, "_valid"}, 32'(instr_valid), 32'd1);
    chk({nm, "_instr"}, instruction, exp_i);
    chk({nm, "_fault"}, 32'(instr_fault), 32'(exp_f));
    step();
  endtask

  initial begin
    prog = '{8'h33, 8'h03, 8'h94, 8'h00, 8'hB3, 8'h03, 8'h39, 8'h41};
    vecs[0] = '{32'd0,           32'h0094_0333, 2'b00};
    vecs[1] = '{32'd4,           32'h4139_03B3, 2'b00};
    vecs[2] = '{32'd8,           32'h0B0A_0908, 2'b00};
    vecs[3] = '{32'd2,           32'h0000_0013, 2'b01};
    vecs[4] = '{32'(D - 2),      32'h0000_0013, 2'b01};
    vecs[5] = '{32'(D),          32'h0000_0013, 2'b10};
    vecs[6] = '{32'(D - 4),      32'h3F3E_3D3C, 2'b00};
    vecs[7] = '{32'hFFFF_FFFC,   32'h0000_0013, 2'b10};
    vecs[8] = '{32'hFFFF_FFFF,   32'h0000_0013, 2'b01};

    // reset state
    fetch_valid = 1'b1;
    step();
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    step();
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_fault", 32'(instr_fault), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    fetch_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("run_fetch_ready", 32'(fetch_ready), 32'd1);
    load_en = 1'b1;
    #1;
    chk("load_en_blocks_fetch", 32'(fetch_ready), 32'd0);

    // overflow stream: D pattern bytes then 3 extra
    step();
    for (int i = 0; i < D + 3; i++) begin
      load_valid = 1'b1;
      load_byte  = (i < D) ? 8'(i) : 8'hAA;
      step();
      if (i == D - 1) chk("full_no_err", 32'(load_err), 32'd0);
    end
    load_valid = 1'b0;
    load_en    = 1'b0;
    step();
    chk("ovf_done", 32'(load_done), 32'd1);
    chk("ovf_count", 32'(load_count), 32'(D));
    chk("ovf_err", 32'(load_err), 32'd1);
    step();
    chk("ovf_done_pulse", 32'(load_done), 32'd0);
    chk("ovf_err_sticky", 32'(load_err), 32'd1);

    // program load
    load_en = 1'b1;
    step();
    chk("entry_err_clr", 32'(load_err), 32'd0);
    chk("entry_count_clr", 32'(load_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1;
      load_byte  = prog[i];
      step();
    end
    load_en   = 1'b0;
    load_byte = 8'hEE;
    step();
    load_valid = 1'b0;
    chk("prog_done", 32'(load_done), 32'd1);
    chk("prog_count", 32'(load_count), 32'd8);
    chk("prog_err", 32'(load_err), 32'd0);

    // fetch table, first fetch in the cycle right after load_done
    for (int i = 0; i < 9; i++)
      fetch_one($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].fault);
    chk("exit_byte_ignored", 32'(load_count), 32'd8);

    // back-to-back fetches 0,4,0
    fetch_valid = 1'b1;
    fetch_pc = 32'd0;
    step();
    chk("b2b0", instruction, 32'h0094_0333);
    chk("b2b0_v", 32'(instr_valid), 32'd1);
    fetch_pc = 32'd4;
    step();
    chk("b2b1", instruction, 32'h4139_03B3);
    chk("b2b1_v", 32'(instr_valid), 32'd1);
    fetch_pc = 32'd0;
    step();
    chk("b2b2", instruction, 32'h0094_0333);
    chk("b2b2_v", 32'(instr_valid), 32'd1);
    fetch_valid = 1'b0;
    step();
    chk("b2b_drain", 32'(instr_valid), 32'd0);

    // back-pressure
    instr_ready = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc = 32'd4;
    step();
    fetch_pc = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), 32'(fetch_ready), 32'd0);
      chk($sformatf("bp_valid%0d", i), 32'(instr_valid), 32'd1);
      chk($sformatf("bp_instr%0d", i), instruction, 32'h4139_03B3);
      step();
    end
    instr_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(fetch_ready), 32'd1);
    step();
    fetch_valid = 1'b0;
    chk("bp_next_instr", instruction, 32'h0094_0333);
    chk("bp_next_valid", 32'(instr_valid), 32'd1);
    step();
    chk("bp_drain", 32'(instr_valid), 32'd0);

    // load requested while a response is pending: must drain first
    instr_ready = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc = 32'd0;
    step();
    fetch_valid = 1'b0;
    load_en = 1'b1;
    step();
    step();
    load_en = 1'b0;
    chk("pend_no_load_done", 32'(load_done), 32'd0);
    step();
    chk("pend_still_no_done", 32'(load_done), 32'd0);
    chk("pend_held", 32'(instr_valid), 32'd1);

    // reset with a pending response discards it
    reset = 1'b1;
    step();
    reset = 1'b0;
    instr_ready = 1'b1;
    chk("rst_discard", 32'(instr_valid), 32'd0);

    // reset mid-load
    load_en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'h51 + 8'(i);
      step();
    end
    load_valid = 1'b0;
    load_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midload_rst_ready", 32'(fetch_ready), 32'd0);
    step();
    reset = 1'b0;
    chk("midload_no_done", 32'(load_done), 32'd0);
    chk("midload_count", 32'(load_count), 32'd0);
    step();
    chk("midload_no_done2", 32'(load_done), 32'd0);
    fetch_one("midload_w0", 32'd0, 32'h5453_5251, 2'b00);
    fetch_one("midload_w1", 32'd4, 32'h4139_0355, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
